// File: rtl/serial_paralelo.sv
// Serial-to-parallel lane receiver: COM (0xBC) byte alignment, run-length lock, byte strobe.
// Optional SP_LOCK_LOSS_EN: drop ACTIVE and realign after two misaligned COMs.
module serial_paralelo #(
    parameter logic [7:0]  COM       = 8'hBC,
    parameter int unsigned COM_COUNT = 4
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       active
);

    typedef enum logic {
        INACTIVE = 1'b0,
        ACTIVE   = 1'b1
    } state_t;

    localparam logic [2:0] COM_TARGET = 3'(COM_COUNT);

    state_t     state;
    state_t     state_n;
    logic [7:0] sr;
    logic [2:0] bit_cnt;
    logic [2:0] bit_cnt_n;
    logic [2:0] com_cnt;
    logic [2:0] com_cnt_n;
    logic [7:0] data_n;
    logic       valid_n;
    logic       boundary;
    logic       is_com;

`ifdef SP_LOCK_LOSS_EN
    logic [1:0] slip_cnt;
    logic [1:0] slip_cnt_n;
`endif

    assign boundary = (bit_cnt == 3'd7);
    assign is_com   = (sr == COM);
    assign active   = (state == ACTIVE);

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            state     <= INACTIVE;
            sr        <= 8'h00;
            bit_cnt   <= 3'd0;
            com_cnt   <= 3'd0;
            data_out  <= 8'h00;
            valid_out <= 1'b0;
`ifdef SP_LOCK_LOSS_EN
            slip_cnt  <= 2'd0;
`endif
        end else begin
            state     <= state_n;
            sr        <= {sr[6:0], data_in};
            bit_cnt   <= bit_cnt_n;
            com_cnt   <= com_cnt_n;
            data_out  <= data_n;
            valid_out <= valid_n;
`ifdef SP_LOCK_LOSS_EN
            slip_cnt  <= slip_cnt_n;
`endif
        end
    end

    always_comb begin
        state_n    = state;
        bit_cnt_n  = bit_cnt + 3'd1;
        com_cnt_n  = com_cnt;
        data_n     = data_out;
        valid_n    = 1'b0;
`ifdef SP_LOCK_LOSS_EN
        slip_cnt_n = slip_cnt;
`endif
        if (state == INACTIVE) begin
            if (com_cnt == 3'd0) begin
                // Hunting: any bit offset may hold the COM; restart the byte phase on it.
                if (is_com) begin
                    bit_cnt_n = 3'd0;
                    com_cnt_n = 3'd1;
                    if (COM_TARGET == 3'd1) begin
                        state_n = ACTIVE;
                    end
                end
            end else if (boundary) begin
                if (is_com) begin
                    com_cnt_n = com_cnt + 3'd1;
                    if (com_cnt + 3'd1 == COM_TARGET) begin
                        state_n = ACTIVE;
                    end
                end else begin
                    com_cnt_n = 3'd0;
                end
            end
        end else begin
            if (boundary) begin
                data_n  = sr;
                valid_n = !is_com;
`ifdef SP_LOCK_LOSS_EN
                if (is_com) begin
                    slip_cnt_n = 2'd0;
                end
            end else if (is_com) begin
                // A second COM at a foreign offset means the lane slipped; lock onto it.
                if (slip_cnt != 2'd0) begin
                    state_n    = (COM_TARGET == 3'd1) ? ACTIVE : INACTIVE;
                    bit_cnt_n  = 3'd0;
                    com_cnt_n  = 3'd1;
                    slip_cnt_n = 2'd0;
                end else begin
                    slip_cnt_n = slip_cnt + 2'd1;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_serial_paralelo.sv
// Directed bench for serial_paralelo: byte-vector table plus hand sequences for reset and slip cases.
// Define SP_LOCK_LOSS_EN for both files to include the lock-loss sequence.
module tb_serial_paralelo;

    logic       clk_32f = 1'b0;
    logic       reset;
    logic       data_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    // din: byte sent MSB first; ev/ed/ea: outputs one cycle after its LSB; la: active at its LSB edge
    typedef struct {
        logic [7:0] din;
        logic       ev;
        logic [7:0] ed;
        logic       ea;
        logic       la;
    } vec_t;

    vec_t       tab[$];
    vec_t       pend;
    bit         have_pend = 1'b0;
    logic [7:0] exp_q[$];

    serial_paralelo dut (
        .clk_32f  (clk_32f),
        .reset    (reset),
        .data_in  (data_in),
        .data_out (data_out),
        .valid_out(valid_out),
        .active   (active)
    );

    always #5 clk_32f = ~clk_32f;

    // Scoreboard: every strobe must match the oldest expected byte.
    always @(negedge clk_32f) begin
        if (valid_out === 1'b1) begin
            vec_cnt++;
            if (exp_q.size() == 0) begin
                miss_cnt++;
                $display("FAIL strobe: got unexpected byte %h, want no strobe", data_out);
            end else begin
                if (data_out !== exp_q[0]) begin
                    miss_cnt++;
                    $display("FAIL strobe: got %h, want %h", data_out, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
        end
    end

    function automatic vec_t mk(input logic [7:0] din, input logic ev, input logic [7:0] ed,
                                input logic ea, input logic la);
        vec_t v;
        v.din = din;
        v.ev  = ev;
        v.ed  = ed;
        v.ea  = ea;
        v.la  = la;
        return v;
    endfunction

    task automatic check(input string name, input logic ev, input logic [7:0] ed, input logic ea);
        vec_cnt++;
        if (valid_out !== ev || data_out !== ed || active !== ea) begin
            miss_cnt++;
            $display("FAIL %s: got valid=%b data=%h active=%b, want valid=%b data=%h active=%b",
                     name, valid_out, data_out, active, ev, ed, ea);
        end
    endtask

    task automatic drive_bit(input logic b);
        data_in = b;
        @(posedge clk_32f);
        #1;
        if (have_pend) begin
            have_pend = 1'b0;
            check($sformatf("byte_%h", pend.din), pend.ev, pend.ed, pend.ea);
        end
    endtask

    task automatic drive_byte(input vec_t v);
        for (int j = 7; j >= 0; j--) begin
            drive_bit(v.din[j]);
        end
        vec_cnt++;
        if (active !== v.la) begin
            miss_cnt++;
            $display("FAIL lsb_active_%h: got %b, want %b", v.din, active, v.la);
        end
        if (v.ev) exp_q.push_back(v.ed);
        pend      = v;
        have_pend = 1'b1;
    endtask

    task automatic run(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            drive_byte(tab[i]);
        end
    endtask

    task automatic do_reset(input int n);
        have_pend = 1'b0;
        reset     = 1'b1;
        for (int i = 0; i < n; i++) begin
            data_in = 1'($urandom_range(0, 1));
            @(posedge clk_32f);
            #1;
            check("reset", 1'b0, 8'h00, 1'b0);
        end
        reset = 1'b0;
    endtask

    task automatic settle();
        drive_bit(1'b0);
        @(negedge clk_32f);
        #1;
        vec_cnt++;
        if (exp_q.size() != 0) begin
            miss_cnt++;
            $display("FAIL missing_strobes: got %0d bytes outstanding, want 0", exp_q.size());
        end
    endtask

    initial begin
        int g_basic, g_post, g_junk, g_rerun, g_lock_a, g_lock_b, g_end;

        g_basic = tab.size();
        repeat (3) tab.push_back(mk(8'hBC, 1'b0, 8'h00, 1'b0, 1'b0));
        tab.push_back(mk(8'hBC, 1'b0, 8'h00, 1'b1, 1'b0));
        tab.push_back(mk(8'hFF, 1'b1, 8'hFF, 1'b1, 1'b1));
        tab.push_back(mk(8'h55, 1'b1, 8'h55, 1'b1, 1'b1));
        tab.push_back(mk(8'h3C, 1'b1, 8'h3C, 1'b1, 1'b1));
        tab.push_back(mk(8'hBC, 1'b0, 8'hBC, 1'b1, 1'b1));
        tab.push_back(mk(8'h7E, 1'b1, 8'h7E, 1'b1, 1'b1));
        g_post = tab.size();
        repeat (3) tab.push_back(mk(8'hBC, 1'b0, 8'h00, 1'b0, 1'b0));
        tab.push_back(mk(8'hBC, 1'b0, 8'h00, 1'b1, 1'b0));
        tab.push_back(mk(8'h5A, 1'b1, 8'h5A, 1'b1, 1'b1));
        g_junk = tab.size();
        repeat (3) tab.push_back(mk(8'hBC, 1'b0, 8'h00, 1'b0, 1'b0));
        tab.push_back(mk(8'hBC, 1'b0, 8'h00, 1'b1, 1'b0));
        tab.push_back(mk(8'hA5, 1'b1, 8'hA5, 1'b1, 1'b1));
        g_rerun = tab.size();
        repeat (3) tab.push_back(mk(8'hBC, 1'b0, 8'h00, 1'b0, 1'b0));
        tab.push_back(mk(8'h11, 1'b0, 8'h00, 1'b0, 1'b0));
        repeat (3) tab.push_back(mk(8'hBC, 1'b0, 8'h00, 1'b0, 1'b0));
        tab.push_back(mk(8'hBC, 1'b0, 8'h00, 1'b1, 1'b0));
        tab.push_back(mk(8'h22, 1'b1, 8'h22, 1'b1, 1'b1));
        g_lock_a = tab.size();
        repeat (3) tab.push_back(mk(8'hBC, 1'b0, 8'h00, 1'b0, 1'b0));
        tab.push_back(mk(8'hBC, 1'b0, 8'h00, 1'b1, 1'b0));
        tab.push_back(mk(8'h3C, 1'b1, 8'h3C, 1'b1, 1'b1));
        g_lock_b = tab.size();
        // After one inserted bit, boundaries see 0x5E; the COMs land one cycle late.
        tab.push_back(mk(8'hBC, 1'b0, 8'h5E, 1'b1, 1'b1));
        tab.push_back(mk(8'hBC, 1'b0, 8'h5E, 1'b0, 1'b1));
        repeat (2) tab.push_back(mk(8'hBC, 1'b0, 8'h5E, 1'b0, 1'b0));
        tab.push_back(mk(8'hBC, 1'b0, 8'h5E, 1'b1, 1'b0));
        tab.push_back(mk(8'h5A, 1'b1, 8'h5A, 1'b1, 1'b1));
        g_end = tab.size();

        reset   = 1'b1;
        data_in = 1'b0;
        do_reset(3);

        run(g_basic, g_post);

        // Reset for one edge partway through 0x96 (bits 1001 | 0 | 110).
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        reset   = 1'b1;
        data_in = 1'b0;
        @(posedge clk_32f);
        #1;
        check("mid_active_reset", 1'b0, 8'h00, 1'b0);
        reset = 1'b0;
        drive_bit(1'b1);
        drive_bit(1'b1);
        drive_bit(1'b0);
        run(g_post, g_junk);
        settle();

        do_reset(2);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        run(g_junk, g_rerun);
        settle();

        do_reset(1);
        run(g_rerun, g_lock_a);
        settle();

`ifdef SP_LOCK_LOSS_EN
        do_reset(1);
        run(g_lock_a, g_lock_b);
        drive_bit(1'b0);
        exp_q.push_back(8'h5E);
        exp_q.push_back(8'h5E);
        run(g_lock_b, g_end);
        settle();
`else
        if (g_end < g_lock_b) $display("table construction error");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
